// File: rtl/fc_act_loader.sv
// Activation frame loader: reorders a pixel-major byte stream into the channel-major
// activation RAM, launches the FC engine, and returns the two class scores.
module fc_act_loader #(
  parameter int N_CH   = 16,
  parameter int N_POS  = 100,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [7:0]        ram_wdata,
  output logic              start_fc,
  input  logic              end_fc,
  input  logic [7:0]        nn_out_male,
  input  logic [7:0]        nn_out_female,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [7:0]        res_male,
  output logic [7:0]        res_female,
  output logic              frame_err,
  output logic [2:0]        dbg_state
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int POS_W = (N_POS > 1) ? $clog2(N_POS) : 1;

  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(N_CH - 1);
  localparam logic [POS_W-1:0]  POS_LAST = POS_W'(N_POS - 1);
  localparam logic [ADDR_W-1:0] POS_STEP = ADDR_W'(N_POS);

  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    DRAIN   = 3'd1,
    START   = 3'd2,
    WAIT_FC = 3'd3,
    RESULT  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_waddr_q, ram_waddr_d;
  logic [7:0]          ram_wdata_q, ram_wdata_d;
  logic                start_fc_q, start_fc_d;
  logic                res_valid_q, res_valid_d;
  logic [7:0]          res_male_q, res_male_d;
  logic [7:0]          res_female_q, res_female_d;
  logic                frame_err_q, frame_err_d;

  logic accept;
  logic final_beat;

  // Handshakes: a beat transfers on a rising edge where in_valid & in_ready;
  // a result transfers on a rising edge where res_valid & res_ready. Neither
  // valid may depend on the matching ready.
  assign in_ready   = (state_q == LOAD);
  assign accept     = in_valid && in_ready;
  assign final_beat = (ch_q == CH_LAST) && (pos_q == POS_LAST);

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    pos_d        = pos_q;
    addr_d       = addr_q;
    ram_we_d     = 1'b0;
    ram_waddr_d  = ram_waddr_q;
    ram_wdata_d  = ram_wdata_q;
    start_fc_d   = 1'b0;
    res_valid_d  = res_valid_q;
    res_male_d   = res_male_q;
    res_female_d = res_female_q;
    frame_err_d  = 1'b0;

    case (state_q)
      LOAD: begin
        if (accept) begin
          ram_we_d    = 1'b1;
          ram_waddr_d = addr_q;
          ram_wdata_d = in_data;
          frame_err_d = (in_last != final_beat);
          if (final_beat) begin
            ch_d    = '0;
            pos_d   = '0;
            addr_d  = '0;
            state_d = DRAIN;
          end else if (ch_q == CH_LAST) begin
            // Channel wrap: next beat is channel 0 of the next position,
            // whose address is simply the new position index.
            ch_d   = '0;
            pos_d  = pos_q + POS_W'(1);
            addr_d = ADDR_W'(pos_q) + ADDR_W'(1);
          end else begin
            ch_d   = ch_q + CH_W'(1);
            addr_d = addr_q + POS_STEP;
          end
        end
      end

      DRAIN: begin
        start_fc_d = 1'b1;
        state_d    = START;
      end

      START: begin
        state_d = WAIT_FC;
      end

      WAIT_FC: begin
        if (end_fc) begin
          res_male_d   = nn_out_male;
          res_female_d = nn_out_female;
          res_valid_d  = 1'b1;
          state_d      = RESULT;
        end
      end

      RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          ch_d        = '0;
          pos_d       = '0;
          addr_d      = '0;
          state_d     = LOAD;
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      ch_q         <= '0;
      pos_q        <= '0;
      addr_q       <= '0;
      ram_we_q     <= 1'b0;
      ram_waddr_q  <= '0;
      ram_wdata_q  <= '0;
      start_fc_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      res_male_q   <= '0;
      res_female_q <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      pos_q        <= pos_d;
      addr_q       <= addr_d;
      ram_we_q     <= ram_we_d;
      ram_waddr_q  <= ram_waddr_d;
      ram_wdata_q  <= ram_wdata_d;
      start_fc_q   <= start_fc_d;
      res_valid_q  <= res_valid_d;
      res_male_q   <= res_male_d;
      res_female_q <= res_female_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign ram_we     = ram_we_q;
  assign ram_waddr  = ram_waddr_q;
  assign ram_wdata  = ram_wdata_q;
  assign start_fc   = start_fc_q;
  assign res_valid  = res_valid_q;
  assign res_male   = res_male_q;
  assign res_female = res_female_q;
  assign frame_err  = frame_err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fc_act_loader.sv
// Bench for fc_act_loader: frame writes scoreboarded against a reference address
// map, plus FC start timing, result handshake, in_last errors and mid-frame reset.
module tb_fc_act_loader;

  localparam int N_CH   = 16;
  localparam int N_POS  = 100;
  localparam int ADDR_W = 12;
  localparam int FRAME  = N_CH * N_POS;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              in_last;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_wdata;
  logic              start_fc;
  logic              end_fc;
  logic [7:0]        nn_out_male;
  logic [7:0]        nn_out_female;
  logic              res_valid;
  logic              res_ready;
  logic [7:0]        res_male;
  logic [7:0]        res_female;
  logic              frame_err;
  logic [2:0]        dbg_state;

  fc_act_loader #(.N_CH(N_CH), .N_POS(N_POS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .start_fc(start_fc), .end_fc(end_fc),
    .nn_out_male(nn_out_male), .nn_out_female(nn_out_female),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_male(res_male), .res_female(res_female),
    .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // {frame_err, addr, data} expected per accepted beat
  logic [ADDR_W+8:0] exp_q[$];
  logic [15:0]       res_q[$];
  logic [7:0]        img[0:FRAME-1];
  int                writes;
  int                err_pulses;
  logic [ADDR_W-1:0] first_addr;

  function automatic logic [7:0] pattern(input int c, input int p);
    return 8'((c * 7 + p) % 256);
  endfunction

  // Drives n_beats beats with ~gap% idle cycles and checks every write cycle.
  task automatic drive_frame(input int gap, input int n_beats, input int extra_last,
                             input bit final_last);
    int beat = 0;
    int cyc = 0;
    int c, p;
    bit acc_prev = 1'b0;
    logic [ADDR_W+8:0] e;
    writes = 0;
    err_pulses = 0;
    first_addr = '1;
    for (int i = 0; i < FRAME; i++) img[i] = 8'hxx;
    while ((beat < n_beats || acc_prev) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (ram_we !== acc_prev) begin
        errors++;
        $display("FAIL ram_we_timing cyc=%0d got=%b want=%b", cyc, ram_we, acc_prev);
      end
      if (acc_prev && ram_we === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({frame_err, ram_waddr, ram_wdata} !== e) begin
          errors++;
          $display("FAIL ram_write got err=%b addr=%0d data=%h want err=%b addr=%0d data=%h",
                   frame_err, ram_waddr, ram_wdata, e[ADDR_W+8], e[ADDR_W+7:8], e[7:0]);
        end
        if (ram_waddr < ADDR_W'(FRAME)) img[ram_waddr] = ram_wdata;
        writes++;
        if (writes == 1) first_addr = ram_waddr;
      end else if (!acc_prev) begin
        checks++;
        if (frame_err !== 1'b0) begin
          errors++;
          $display("FAIL frame_err_idle got=%b want=0", frame_err);
        end
      end
      if (frame_err === 1'b1) err_pulses++;
      checks++;
      if (start_fc !== 1'b0) begin
        errors++;
        $display("FAIL start_fc_early cyc=%0d got=%b want=0", cyc, start_fc);
      end
      if (beat < n_beats) begin
        c = beat % N_CH;
        p = beat / N_CH;
        in_valid = ($urandom_range(99) >= gap);
        in_data  = pattern(c, p);
        in_last  = (beat == extra_last) || (final_last && beat == FRAME - 1);
        acc_prev = in_valid && in_ready;
        if (acc_prev) begin
          exp_q.push_back({(in_last != (beat == FRAME - 1)), ADDR_W'(c * N_POS + p), in_data});
          beat++;
        end
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        acc_prev = 1'b0;
      end
    end
    checks++;
    if (cyc >= 20000 || writes != n_beats || exp_q.size() != 0) begin
      errors++;
      $display("FAIL frame_writes got=%0d want=%0d pending=%0d", writes, n_beats, exp_q.size());
      exp_q.delete();
    end
    if (n_beats == FRAME) begin
      @(negedge clk);
      checks++;
      if (start_fc !== 1'b1 || ram_we !== 1'b0) begin
        errors++;
        $display("FAIL start_fc_pulse got start=%b we=%b want start=1 we=0", start_fc, ram_we);
      end
      @(negedge clk);
      checks++;
      if (start_fc !== 1'b0 || in_ready !== 1'b0 || res_valid !== 1'b0) begin
        errors++;
        $display("FAIL start_fc_width got start=%b rdy=%b rv=%b want 0 0 0",
                 start_fc, in_ready, res_valid);
      end
    end
  endtask

  task automatic check_image();
    int bad = 0;
    for (int c = 0; c < N_CH; c++)
      for (int p = 0; p < N_POS; p++)
        if (img[c * N_POS + p] !== pattern(c, p)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ram_image got %0d bad bytes want 0", bad);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    end_fc = 1'b0; nn_out_male = '0; nn_out_female = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ram_we, start_fc, res_valid, frame_err, res_male, res_female, in_ready, dbg_state}
        !== {4'b0, 16'h0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL reset_state got we=%b st=%b rv=%b fe=%b m=%h f=%h rdy=%b s=%0d",
               ram_we, start_fc, res_valid, frame_err, res_male, res_female, in_ready, dbg_state);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_end_fc_ignored();
    end_fc = 1'b1; nn_out_male = 8'hAA; nn_out_female = 8'h55;
    @(negedge clk);
    end_fc = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || in_ready !== 1'b1 || res_male !== 8'h00) begin
        errors++;
        $display("FAIL end_fc_in_load got rv=%b rdy=%b m=%h want 0 1 00",
                 res_valid, in_ready, res_male);
      end
    end
  endtask

  task automatic test_full_frame();
    drive_frame(0, FRAME, -1, 1'b1);
    checks++;
    if (img[100] !== 8'd7 || img[1] !== 8'd1 || img[FRAME-1] !== pattern(N_CH-1, N_POS-1)) begin
      errors++;
      $display("FAIL full_frame_spots got a100=%h a1=%h a1599=%h want 07 01 %h",
               img[100], img[1], img[FRAME-1], pattern(N_CH-1, N_POS-1));
    end
    check_image();
  endtask

  task automatic test_result(input logic [7:0] m, input logic [7:0] f);
    logic [15:0] exp;
    end_fc = 1'b1; nn_out_male = m; nn_out_female = f;
    res_q.push_back({m, f});
    @(negedge clk);
    end_fc = 1'b0;
    nn_out_male = 8'($urandom); nn_out_female = 8'($urandom);
    exp = res_q.pop_front();
    checks++;
    if (res_valid !== 1'b1 || {res_male, res_female} !== exp) begin
      errors++;
      $display("FAIL result_capture got rv=%b %h/%h want 1 %h/%h",
               res_valid, res_male, res_female, exp[15:8], exp[7:0]);
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || {res_male, res_female} !== exp || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL result_hold got rv=%b %h/%h rdy=%b want 1 %h/%h 0",
                 res_valid, res_male, res_female, in_ready, exp[15:8], exp[7:0]);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL result_release got rv=%b rdy=%b want 0 1", res_valid, in_ready);
    end
  endtask

  task automatic test_gaps();
    drive_frame(30, FRAME, -1, 1'b1);
    check_image();
    test_result(8'($urandom), 8'($urandom));
  endtask

  task automatic test_in_last_errors();
    drive_frame(0, FRAME, 800, 1'b0);
    checks++;
    if (err_pulses != 2) begin
      errors++;
      $display("FAIL frame_err_count got=%0d want=2", err_pulses);
    end
    test_result(8'h01, 8'h80);
  endtask

  task automatic test_reset_mid_frame();
    drive_frame(0, 500, -1, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_we, start_fc, res_valid, frame_err, res_male, res_female, ram_waddr, ram_wdata,
         in_ready} !== {4'b0, 16'h0, 20'h0, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset got we=%b st=%b rv=%b fe=%b m=%h f=%h a=%0d d=%h rdy=%b",
               ram_we, start_fc, res_valid, frame_err, res_male, res_female,
               ram_waddr, ram_wdata, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_frame(0, FRAME, -1, 1'b1);
    checks++;
    if (first_addr !== '0) begin
      errors++;
      $display("FAIL post_reset_first_addr got=%0d want=0", first_addr);
    end
    check_image();
    test_result(8'h7F, 8'h00);
  endtask

  initial begin
    test_reset();
    test_end_fc_ignored();
    test_full_frame();
    test_result(8'h12, 8'hF3);
    test_gaps();
    test_in_last_errors();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
